// File: rtl/axi_lite_cmd_master_pkg.sv
// Shared types and AXI response codes for the command-to-AXI4-Lite master.
// The FSM state enum lives here so the top and any debug logic agree on one encoding.
package axi_lite_cmd_master_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Width of a counter that must hold values 0..limit-1.
  function automatic int count_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/ifc_axi4_lite.sv
// AXI4-Lite bundle with master and slave views.
interface ifc_axi4_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_cmd_timeout.sv
// Per-transaction watchdog: restarts on start, idles at zero under clear,
// otherwise counts up and saturates at TIMEOUT_CYCLES-1.
module axi_lite_cmd_timeout
  import axi_lite_cmd_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CW = count_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (start || clear) begin
      count_reg <= '0;
    end else if (count_reg != LIMIT) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Reaching LIMIT means the edge about to come is the TIMEOUT_CYCLES-th since acceptance.
  assign expired = !clear && (count_reg == LIMIT);

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Turns single read/write commands into AXI4-Lite transactions and returns one
// response per command, aborting with SLVERR if the slave stalls too long.
module axi_lite_cmd_master
  import axi_lite_cmd_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  ifc_axi4_lite.master            if_axi
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t                  state_reg;
  logic                    cmd_ready_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [STRB_WIDTH-1:0]   wstrb_reg;
  logic                    awvalid_reg;
  logic                    wvalid_reg;
  logic                    aw_done_reg;
  logic                    w_done_reg;
  logic                    bready_reg;
  logic                    arvalid_reg;
  logic                    rready_reg;
  logic                    rsp_valid_reg;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
  logic [1:0]              rsp_resp_reg;
  logic                    rsp_timeout_reg;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic accept, expired, abort, timer_clear;

  assign aw_hs  = awvalid_reg && if_axi.awready;
  assign w_hs   = wvalid_reg  && if_axi.wready;
  assign b_hs   = bready_reg  && if_axi.bvalid;
  assign ar_hs  = arvalid_reg && if_axi.arready;
  assign r_hs   = rready_reg  && if_axi.rvalid;
  assign accept = (state_reg == IDLE) && cmd_valid && cmd_ready_reg;
  assign timer_clear = (state_reg == IDLE) || (state_reg == RSP);

  // A completing B/R handshake on the expiry edge still wins over the abort.
  always_comb begin
    abort = 1'b0;
    case (state_reg)
      WR_REQ, RD_REQ: abort = expired;
      WR_RESP:        abort = expired && !b_hs;
      RD_RESP:        abort = expired && !r_hs;
      default:        abort = 1'b0;
    endcase
  end

  axi_lite_cmd_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .clear   (timer_clear),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cmd_ready_reg   <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      wstrb_reg       <= '0;
      awvalid_reg     <= 1'b0;
      wvalid_reg      <= 1'b0;
      aw_done_reg     <= 1'b0;
      w_done_reg      <= 1'b0;
      bready_reg      <= 1'b0;
      arvalid_reg     <= 1'b0;
      rready_reg      <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_resp_reg    <= OKAY;
      rsp_timeout_reg <= 1'b0;
    end else if (abort) begin
      state_reg       <= RSP;
      awvalid_reg     <= 1'b0;
      wvalid_reg      <= 1'b0;
      bready_reg      <= 1'b0;
      arvalid_reg     <= 1'b0;
      rready_reg      <= 1'b0;
      rsp_valid_reg   <= 1'b1;
      rsp_rdata_reg   <= '0;
      rsp_resp_reg    <= SLVERR;
      rsp_timeout_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            cmd_ready_reg <= 1'b0;
            addr_reg      <= cmd_addr;
            wdata_reg     <= cmd_wdata;
            wstrb_reg     <= cmd_wstrb;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            if (cmd_write) begin
              state_reg   <= WR_REQ;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
            end else begin
              state_reg   <= RD_REQ;
              arvalid_reg <= 1'b1;
            end
          end else begin
            cmd_ready_reg <= 1'b1;
          end
        end

        WR_REQ: begin
          if (aw_hs) begin
            awvalid_reg <= 1'b0;
            aw_done_reg <= 1'b1;
          end
          if (w_hs) begin
            wvalid_reg <= 1'b0;
            w_done_reg <= 1'b1;
          end
          // Address and data may complete in either order or together.
          if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
            state_reg  <= WR_RESP;
            bready_reg <= 1'b1;
          end
        end

        WR_RESP: begin
          if (b_hs) begin
            state_reg       <= RSP;
            bready_reg      <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= if_axi.bresp;
            rsp_timeout_reg <= 1'b0;
          end
        end

        RD_REQ: begin
          if (ar_hs) begin
            state_reg   <= RD_RESP;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
          end
        end

        RD_RESP: begin
          if (r_hs) begin
            state_reg       <= RSP;
            rready_reg      <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_rdata_reg   <= if_axi.rdata;
            rsp_resp_reg    <= if_axi.rresp;
            rsp_timeout_reg <= 1'b0;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_resp    = rsp_resp_reg;
  assign rsp_timeout = rsp_timeout_reg;

  assign if_axi.awvalid = awvalid_reg;
  assign if_axi.awaddr  = addr_reg;
  assign if_axi.awprot  = 3'b000;
  assign if_axi.wvalid  = wvalid_reg;
  assign if_axi.wdata   = wdata_reg;
  assign if_axi.wstrb   = wstrb_reg;
  assign if_axi.bready  = bready_reg;
  assign if_axi.arvalid = arvalid_reg;
  assign if_axi.araddr  = addr_reg;
  assign if_axi.arprot  = 3'b000;
  assign if_axi.rready  = rready_reg;

endmodule

// File: doc/axi_lite_cmd_master.md
AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, AXI data width (32 or 64).
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 256, cycles before a transaction is aborted (>=2).
REQ-004 The module SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  synchronous reset.
REQ-005 The module SHALL have port cmd_valid  in  1  command request.
REQ-006 The module SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 The module SHALL have port cmd_write  in  1  1=write, 0=read.
REQ-008 The module SHALL have port cmd_addr  in  ADDR_WIDTH  byte address.
REQ-009 The module SHALL have port cmd_wdata  in  DATA_WIDTH  write data.
REQ-010 The module SHALL have port cmd_wstrb  in  DATA_WIDTH/8  write strobes.
REQ-011 The module SHALL have port rsp_valid  out  1  response available.
REQ-012 The module SHALL have port rsp_ready  in  1  response consumed.
REQ-013 The module SHALL have port rsp_rdata  out  DATA_WIDTH  read data (0 for writes).
REQ-014 The module SHALL have port rsp_resp  out  2  AXI response code.
REQ-015 The module SHALL have port rsp_timeout  out  1  transaction aborted by timeout.
REQ-016 The module SHALL have port if_axi  ifc_axi4_lite master  -  AXI4-Lite master towards the register-file slave.

Function
REQ-017 The module SHALL use FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
REQ-018 cmd_ready SHALL be high only in IDLE; a handshake latches all cmd_* inputs and moves to WR_REQ (cmd_write=1) or RD_REQ.
REQ-019 awvalid and wvalid SHALL both assert in the cycle after acceptance, each independently held until its own handshake.
REQ-020 The module SHALL enter WR_RESP once both the AW and W handshakes are done, including same-cycle and either-order completion.
REQ-021 bready SHALL be high only in WR_RESP; the B handshake captures bresp and moves the FSM to RSP.
REQ-022 arvalid SHALL assert in the cycle after acceptance and hold until arready; the module SHALL then move to RD_RESP.
REQ-023 rready SHALL be high only in RD_RESP; the R handshake captures rdata and rresp and moves the FSM to RSP.
REQ-024 In RSP, rsp_valid SHALL be high with stable payload until rsp_ready, then return to IDLE; a new command SHALL be accepted at the earliest on the cycle after the response handshake.
REQ-025 All AXI outputs and rsp_* SHALL be registered; awprot=arprot=3'b000.
REQ-026 A cycle counter SHALL reset on command acceptance; if TIMEOUT_CYCLES elapse without reaching RSP, all valid/ready outputs SHALL deassert and the FSM SHALL enter RSP with rsp_resp=SLVERR, rsp_timeout=1, rsp_rdata=0. This is a deliberate non-AXI-compliant abort.
REQ-027 The counter SHALL saturate and not wrap; rsp_timeout SHALL be 0 for normally completed transactions.
REQ-028 Slave DECERR/SLVERR SHALL be forwarded unchanged in rsp_resp.

Reset
REQ-029 While rst=1, the FSM SHALL be IDLE and all outputs SHALL be 0, except cmd_ready, which SHALL be 1 from the first cycle after reset release.
REQ-030 Reset mid-transaction SHALL abandon the transaction without a response; no valid SHALL stay high after the reset cycle.

Structure
REQ-031 Package axi_lite_cmd_master_pkg SHALL hold the FSM state enum and the AXI response constants (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11).
REQ-032 The timeout counter SHALL be the sub-module axi_lite_cmd_timeout (start, clear, expired).

Verification
REQ-033 Against axi_lite_reg_file_direct_access (base 0x20, ADD_READ_LATENCY=1): write 0xDEADBEEF to 0x24 with wstrb=0xF, then read 0x24 -> rsp_rdata=0xDEADBEEF, rsp_resp=OKAY.
REQ-034 Slave model delays awready by 3 cycles and wready by 0 -> wvalid drops after 1 cycle, awvalid stays high 4 cycles, exactly one response.
REQ-035 Read with slave never asserting arready, TIMEOUT_CYCLES=16 -> rsp_valid 16 cycles after acceptance, rsp_resp=2'b10, rsp_timeout=1.
REQ-036 rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready low throughout.
REQ-037 Assert rst in WR_RESP -> next cycle bready=0, rsp_valid=0, cmd_ready=1 after release.
REQ-038 Slave returns DECERR on read -> rsp_resp=2'b11, rsp_timeout=0.
